// File: rtl/process_timer.sv
// process_timer: measures how long the system stays in the execute state.
// A prescaler divides clk into time units of PRESCALE cycles. The result is
// held stable from the end of a measurement until the next one begins, and a
// one-cycle pulse asks the downstream BCD converter to pick it up.
// Optional feature: define PROCESS_TIMER_SAT_EN to make timeValue saturate at
// its maximum and raise a sticky overflow flag. When the macro is undefined,
// timeValue wraps modulo 2^26 and overflow stays 0.
// TIME_PRELOAD is the value loaded into timeValue on entry to RUN. Leave it at
// 0 for normal use; a non-zero value lets a bench reach the counter limit
// without millions of cycles. Reset always clears timeValue to 0.
module process_timer #(
  parameter int          PRESCALE     = 50,
  parameter logic [25:0] TIME_PRELOAD = 26'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  state,
  output logic [25:0] timeValue,
  output logic        start_timeValue_convetion,
  output logic        running,
  output logic        overflow
);

  // Enough bits to hold PRESCALE itself, so PRESCALE-1 never truncates.
  localparam int PW = $clog2(PRESCALE + 1);
  localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

  localparam logic [2:0] ST_UART_READY = 3'd0;
  localparam logic [2:0] ST_EXECUTE    = 3'd4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    REPORT = 2'd2,
    DONE   = 2'd3
  } fsm_t;

  fsm_t          r_fsm;
  logic [PW-1:0] r_prescale;
  logic [25:0]   r_time;
  logic          r_running;
  logic          r_pulse;

  logic          w_exec;
  logic          w_idle_req;
  logic          w_unit_done;
  logic [PW-1:0] w_prescale_inc;
  logic [25:0]   w_time_inc;

  assign w_exec         = (state == ST_EXECUTE);
  assign w_idle_req     = (state == ST_UART_READY);
  assign w_unit_done    = (r_prescale == PS_LAST);
  assign w_prescale_inc = r_prescale + PW'(1);
  assign w_time_inc     = r_time + 26'd1;

`ifdef PROCESS_TIMER_SAT_EN
  logic r_overflow;
  logic w_time_max;

  assign w_time_max = (r_time == 26'h3FFFFFF);

  // Sticky overflow: set by an increment attempt at max, cleared on RUN entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow <= 1'b0;
    end else if ((r_fsm == IDLE || r_fsm == DONE) && w_exec) begin
      r_overflow <= 1'b0;
    end else if (r_fsm == RUN && w_exec && w_unit_done && w_time_max) begin
      r_overflow <= 1'b1;
    end
  end

  assign overflow = r_overflow;
`else
  assign overflow = 1'b0;
`endif

  // Measurement FSM: owns the prescaler, the time count and the status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fsm      <= IDLE;
      r_prescale <= '0;
      r_time     <= '0;
      r_running  <= 1'b0;
      r_pulse    <= 1'b0;
    end else begin
      r_pulse <= 1'b0;
      case (r_fsm)
        IDLE: begin
          if (w_exec) begin
            r_fsm      <= RUN;
            r_prescale <= '0;
            r_time     <= TIME_PRELOAD;
            r_running  <= 1'b1;
          end
        end
        RUN: begin
          if (w_exec) begin
            if (w_unit_done) begin
              r_prescale <= '0;
`ifdef PROCESS_TIMER_SAT_EN
              if (!w_time_max) begin
                r_time <= w_time_inc;
              end
`else
              r_time <= w_time_inc;
`endif
            end else begin
              r_prescale <= w_prescale_inc;
            end
          end else begin
            // Execution ended: freeze the count and announce it once.
            r_fsm     <= REPORT;
            r_running <= 1'b0;
            r_pulse   <= 1'b1;
          end
        end
        REPORT: begin
          r_fsm <= DONE;
        end
        DONE: begin
          if (w_exec) begin
            r_fsm      <= RUN;
            r_prescale <= '0;
            r_time     <= TIME_PRELOAD;
            r_running  <= 1'b1;
          end else if (w_idle_req) begin
            r_fsm <= IDLE;
          end
        end
        default: begin
          r_fsm <= IDLE;
        end
      endcase
    end
  end

  assign timeValue                 = r_time;
  assign start_timeValue_convetion = r_pulse;
  assign running                   = r_running;

endmodule

// File: tb/tb_process_timer.sv
// Bench for process_timer: three instances (PRESCALE=1, PRESCALE=50, and
// PRESCALE=1 with a near-maximum preload). Stimulus pushes the expected
// result of each measurement into a per-instance queue; monitors pop and
// compare whenever the DUT raises its conversion pulse.
module tb_process_timer;

  typedef struct {
    logic [25:0] tv;
    int          run_cycles;
    logic        ovf;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Instance A: PRESCALE=1
  logic        r1, ov1, p1, run1_o;
  logic [2:0]  s1;
  logic [25:0] tv1;
  // Instance B: PRESCALE=50
  logic        r50, ov50, p50, run50_o;
  logic [2:0]  s50;
  logic [25:0] tv50;
  // Instance C: PRESCALE=1, preload near max
  logic        rp, ovp, pp, runp_o;
  logic [2:0]  sp;
  logic [25:0] tvp;

  exp_t q1[$];
  exp_t q50[$];
  exp_t qp[$];

`ifdef PROCESS_TIMER_SAT_EN
  localparam logic [25:0] PRE_TV  = 26'h3FFFFFF;
  localparam logic        PRE_OVF = 1'b1;
`else
  localparam logic [25:0] PRE_TV  = 26'h0000001;
  localparam logic        PRE_OVF = 1'b0;
`endif

  process_timer #(.PRESCALE(1)) dut1 (
    .clk(clk), .rst(r1), .state(s1), .timeValue(tv1),
    .start_timeValue_convetion(p1), .running(run1_o), .overflow(ov1)
  );

  process_timer #(.PRESCALE(50)) dut50 (
    .clk(clk), .rst(r50), .state(s50), .timeValue(tv50),
    .start_timeValue_convetion(p50), .running(run50_o), .overflow(ov50)
  );

  process_timer #(.PRESCALE(1), .TIME_PRELOAD(26'h3FFFFFE)) dutp (
    .clk(clk), .rst(rp), .state(sp), .timeValue(tvp),
    .start_timeValue_convetion(pp), .running(runp_o), .overflow(ovp)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor A: count running cycles, check each pulse against the queue.
  int  rc1 = 0;
  bit  prev1 = 0;
  always @(negedge clk) begin
    exp_t e;
    if (r1) rc1 = 0;
    else if (run1_o) rc1++;
    if (p1) begin
      chk("A_pulse_single", {31'd0, prev1}, 32'd0);
      chk("A_pulse_expected", {31'd0, q1.size() != 0}, 32'd1);
      if (q1.size() != 0) begin
        e = q1.pop_front();
        chk("A_timeValue", {6'd0, tv1}, {6'd0, e.tv});
        chk("A_running_cycles", rc1, e.run_cycles);
        chk("A_overflow", {31'd0, ov1}, {31'd0, e.ovf});
        $display("A pulse: timeValue=%0d running_cycles=%0d overflow=%0b", tv1, rc1, ov1);
      end
      rc1 = 0;
    end
    prev1 = p1;
  end

  // Monitor B
  int  rc50 = 0;
  bit  prev50 = 0;
  always @(negedge clk) begin
    exp_t e;
    if (r50) rc50 = 0;
    else if (run50_o) rc50++;
    if (p50) begin
      chk("B_pulse_single", {31'd0, prev50}, 32'd0);
      chk("B_pulse_expected", {31'd0, q50.size() != 0}, 32'd1);
      if (q50.size() != 0) begin
        e = q50.pop_front();
        chk("B_timeValue", {6'd0, tv50}, {6'd0, e.tv});
        chk("B_running_cycles", rc50, e.run_cycles);
        chk("B_overflow", {31'd0, ov50}, {31'd0, e.ovf});
        $display("B pulse: timeValue=%0d running_cycles=%0d overflow=%0b", tv50, rc50, ov50);
      end
      rc50 = 0;
    end
    prev50 = p50;
  end

  // Monitor C
  int  rcp = 0;
  bit  prevp = 0;
  always @(negedge clk) begin
    exp_t e;
    if (rp) rcp = 0;
    else if (runp_o) rcp++;
    if (pp) begin
      chk("C_pulse_single", {31'd0, prevp}, 32'd0);
      chk("C_pulse_expected", {31'd0, qp.size() != 0}, 32'd1);
      if (qp.size() != 0) begin
        e = qp.pop_front();
        chk("C_timeValue", {6'd0, tvp}, {6'd0, e.tv});
        chk("C_running_cycles", rcp, e.run_cycles);
        chk("C_overflow", {31'd0, ovp}, {31'd0, e.ovf});
        $display("C pulse: timeValue=%0h running_cycles=%0d overflow=%0b", tvp, rcp, ovp);
      end
      rcp = 0;
    end
    prevp = pp;
  end

  // Watchdog: the directed sequence is far shorter than this.
  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    s1 = 3'd0; s50 = 3'd0; sp = 3'd0;
    r1 = 1'b1; r50 = 1'b1; rp = 1'b1;
    step(2);
    r1 = 1'b0; r50 = 1'b0; rp = 1'b0;

    // Reset state
    chk("A_reset_timeValue", {6'd0, tv1}, 32'd0);
    chk("A_reset_running", {31'd0, run1_o}, 32'd0);
    chk("A_reset_pulse", {31'd0, p1}, 32'd0);
    chk("A_reset_overflow", {31'd0, ov1}, 32'd0);
    chk("B_reset_timeValue", {6'd0, tv50}, 32'd0);
    chk("C_reset_timeValue", {6'd0, tvp}, 32'd0);
    $display("reset: A tv=%0d B tv=%0d C tv=%0d", tv1, tv50, tvp);

    // A: 11 execute edges -> 10, running 11 cycles
    s1 = 3'd4;
    q1.push_back(exp_t'{26'd10, 11, 1'b0});
    step(11);
    s1 = 3'd6;
    step(4);
    chk("A_done_hold_timeValue", {6'd0, tv1}, 32'd10);
    chk("A_done_running", {31'd0, run1_o}, 32'd0);
    $display("A done: timeValue=%0d", tv1);

    // A: state=0 returns to IDLE holding 10, no pulse
    s1 = 3'd0;
    step(3);
    chk("A_idle_hold_timeValue", {6'd0, tv1}, 32'd10);
    $display("A idle: timeValue=%0d", tv1);

    // A: 3 execute edges -> 2
    s1 = 3'd4;
    q1.push_back(exp_t'{26'd2, 3, 1'b0});
    step(3);
    s1 = 3'd5;
    step(3);

    // A: reset mid-run, then 4 execute edges -> 3, single pulse
    s1 = 3'd4;
    q1.push_back(exp_t'{26'd3, 4, 1'b0});
    step(6);
    r1 = 1'b1;
    step(1);
    chk("A_midrun_reset_timeValue", {6'd0, tv1}, 32'd0);
    chk("A_midrun_reset_running", {31'd0, run1_o}, 32'd0);
    r1 = 1'b0;
    step(4);
    s1 = 3'd6;
    step(3);

    // B: 501 edges -> 10, then DONE -> RUN, 500 edges -> 9
    s50 = 3'd4;
    q50.push_back(exp_t'{26'd10, 501, 1'b0});
    step(501);
    s50 = 3'd6;
    step(3);
    chk("B_hold_10", {6'd0, tv50}, 32'd10);
    s50 = 3'd4;
    q50.push_back(exp_t'{26'd9, 500, 1'b0});
    step(500);
    s50 = 3'd6;
    step(3);
    chk("B_hold_9", {6'd0, tv50}, 32'd9);
    $display("B done: timeValue=%0d", tv50);

    // C: preload 3FFFFFE, 3 increments
    sp = 3'd4;
    qp.push_back(exp_t'{PRE_TV, 4, PRE_OVF});
    step(4);
    sp = 3'd6;
    step(3);
    chk("C_hold_timeValue", {6'd0, tvp}, {6'd0, PRE_TV});
    chk("C_hold_overflow", {31'd0, ovp}, {31'd0, PRE_OVF});
    $display("C done: timeValue=%0h overflow=%0b", tvp, ovp);

    // Every expected pulse arrived
    chk("A_queue_drained", q1.size(), 32'd0);
    chk("B_queue_drained", q50.size(), 32'd0);
    chk("C_queue_drained", qp.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/process_timer.md
PROCESS_TIMER -- requirements
Module: process_timer

Interface
REQ-001 Parameter PRESCALE, default 50, clock cycles per time unit (50 gives 1 us at 50 MHz); legal range 1..1023.
REQ-002 Clock and reset: one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  system clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 state  input  3  system state code: 0 uart_ready, 1 uart_receive_Imem, 2 uart_receive_dmem, 3 process_ready, 4 process_exicute, 5 uart_transmit_dmem, 6 finish.
REQ-006 timeValue  output  26  measured execution time in PRESCALE units, binary; feeds the seven-segment display converter.
REQ-007 start_timeValue_convetion  output  1  one-cycle pulse requesting BCD conversion of timeValue.
REQ-008 running  output  1  high while a measurement is in progress.
REQ-009 overflow  output  1  sticky flag: the count reached its maximum.

Function
REQ-010 Internal FSM states: IDLE, RUN, REPORT, DONE; all outputs registered.
REQ-011 IDLE: on an edge sampling state==4 -> RUN; timeValue, prescaler and overflow are cleared on that edge.
REQ-012 RUN, edge sampling state==4: prescaler increments; at PRESCALE-1 it wraps to 0 and timeValue increments on the same edge.
REQ-013 RUN, edge sampling state!=4 -> REPORT; no increment on that edge.
REQ-014 Result: state==4 sampled on N consecutive edges gives timeValue = floor((N-1)/PRESCALE).
REQ-015 REPORT: start_timeValue_convetion high for exactly this one cycle; next edge -> DONE unconditionally.
REQ-016 DONE: timeValue held; state==4 sampled -> RUN with the clears of REQ-011; state==0 sampled -> IDLE with timeValue held; any other state -> stay.
REQ-017 timeValue does not change from entry to REPORT until the next entry to RUN, so the downstream converter always sees a stable value.
REQ-018 running = 1 exactly in RUN; pulse = 1 exactly in REPORT.
REQ-019 PRESCALE=1: timeValue increments on every RUN edge sampling state==4.
REQ-020 Prescaler width is ceil(log2(PRESCALE+1)) bits; compares use PRESCALE-1 with no truncation.

Reset
REQ-021 rst sampled high -> IDLE, timeValue=0, prescaler=0, running=0, start_timeValue_convetion=0, overflow=0.
REQ-022 rst has priority over every transition, including mid-RUN and in REPORT; a pulse cut off by reset is not reissued.
REQ-023 First edge after rst deasserts follows REQ-011 normally.

Configuration
REQ-024 Macro PROCESS_TIMER_SAT_EN defined: timeValue saturates at 26'h3FFFFFF; an increment attempt at max sets overflow, which stays set until the next RUN entry or reset.
REQ-025 Macro PROCESS_TIMER_SAT_EN undefined: timeValue wraps modulo 2^26; overflow is tied to 0.

Verification
REQ-026 PRESCALE=1, rst then state=4 for 11 edges, then state=6 -> running high 11 cycles, one pulse, timeValue=10, held through DONE.
REQ-027 PRESCALE=50, state=4 for 501 edges -> timeValue=10; state=4 for 500 edges -> timeValue=9.
REQ-028 PRESCALE=1, state=4 for 6 edges, rst pulsed for 1 cycle mid-run, then state=4 for 4 edges, state=6 -> timeValue=3, exactly one pulse after reset.
REQ-029 DONE with timeValue=10, state=0 then state=4 for 3 edges, state=5 -> timeValue=2; state=0 alone leaves timeValue=10 and no pulse.
REQ-030 Force timeValue=26'h3FFFFFE via preload, PRESCALE=1, 3 more counting edges -> with PROCESS_TIMER_SAT_EN: 26'h3FFFFFF, overflow=1; without: 26'h0000001, overflow=0.
